led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator for board status and demo LEDs; successor to the fixed 4-LED running light.
- Runs entirely on `sys_clk`. A prescaler produces a clock-enable step strobe; there is no derived clock and no logic is clocked by a generated signal.
- Generalised in LED count, step period and output polarity.
- Adds run-time selection of four patterns and a pause input.

Parameters:
- LED_NUM, 4: number of LEDs. Legal values are 2 and above.
- CNT_MAX, 24_999_999: step period minus 1, in `sys_clk` cycles. Legal values are 1 and above. The counter width is clog2(CNT_MAX+1).
- ACTIVE_LOW, 1: output polarity. 1 means an LED is lit when its pin is driven 0. 0 means an LED is lit when its pin is driven 1.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- en  in  1  1 = run, 0 = pause (prescaler and pattern hold)
- mode  in  2  pattern select: 00 rotate-right, 01 rotate-left, 10 bounce, 11 fill bar
- led  out  LED_NUM  LED drive, registered
- step_pulse  out  1  one-cycle strobe in the first cycle of each new pattern

Behaviour:
- Clock and reset: one clock, `sys_clk`. Reset is asynchronous and active-low on `sys_rst_n`. Reset may assert at any time and takes effect immediately.
- Internal state:
  - `pat[LED_NUM-1:0]`, active-high lit map.
  - `cnt`, prescaler counter.
  - `dir`, bounce direction; 0 = moving toward the LSB.
  - `level`, fill level, range 0..LED_NUM.
  - `mode_q`, registered copy of `mode`.
- Output mapping: `led` is the registered value of ACTIVE_LOW ? ~pat : pat.
- Reset values:
  - cnt = 0, dir = 0, level = 0.
  - mode_q = `mode` value sampled during reset.
  - pat = one-hot MSB.
  - led accordingly (LED_NUM=4, ACTIVE_LOW=1 gives 0111).
  - step_pulse = 0.
- Prescaler:
  - When en=1, cnt counts 0..CNT_MAX and wraps to 0.
  - When en=0, cnt holds its value.
  - tick = (en=1 and cnt==CNT_MAX).
- Step on tick: pat, led and step_pulse all update on the same clock edge. The first step occurs CNT_MAX+1 enabled cycles after reset release.
- Mode 00, rotate-right: bit i moves to bit i-1; bit 0 wraps to the MSB.
- Mode 01, rotate-left: bit i moves to bit i+1; the MSB wraps to bit 0.
- Mode 10, bounce: the one-hot bit moves one position per step in direction `dir`.
  - At bit 0 with dir=0: dir becomes 1 and the bit moves to bit 1. There is no dwell at the end.
  - At the MSB with dir=1: dir becomes 0 and the bit moves to bit LED_NUM-2.
  - Period is 2*(LED_NUM-1) steps.
- Mode 11, fill:
  - level advances 0→1→…→LED_NUM→0 on each step.
  - pat lights the top `level` bits (level 0 = all LEDs off).
  - Period is LED_NUM+1 steps.
- Mode change: detected as `mode` != `mode_q` on a clock edge. On that edge:
  - mode_q is updated to `mode`.
  - cnt is set to 0.
  - dir is set to 0.
  - The pattern reloads to the new mode's start state: one-hot MSB for modes 00/01/10; level=0 and all LEDs off for mode 11.
  - step_pulse stays 0.
  - Reload takes priority over a coincident tick.
  - Reload occurs regardless of `en`.
- step_pulse: set to 1 on a tick edge and cleared on every other edge. It is never high for two consecutive cycles. This holds even when CNT_MAX=1, because a tick occurs at most every other cycle.
- Pause: while en=0, the pattern, cnt, dir and level are frozen. When en returns to 1, counting resumes from the held cnt.
- Reset during operation: all state returns immediately to the reset values, with no dependence on the clock edge.

Test Plan (LED_NUM=4, CNT_MAX=3, ACTIVE_LOW=1, en=1 unless stated):
- Reset, then mode=00 → led=0111 at release, then 1011, 1101, 1110, 0111 every 4 clocks. step_pulse is high for one cycle at each change and in no other cycle.
- mode=01 held from reset → led sequence 0111, 1110, 1101, 1011, 0111.
- mode=10 → lit-bit sequence 3,2,1,0,1,2,3,2, i.e. led 0111, 1011, 1101, 1110, 1101, 1011, 0111, 1011.
- mode=11 → led sequence 1111, 0111, 0011, 0001, 0000, 1111.
- Pause and mode change:
  - en=0 for 10 cycles when cnt=2 → led and cnt are frozen. After en returns to 1, the next step occurs 2 enabled cycles later.
  - mode changed 00→11 on the same edge as a tick → led=1111, step_pulse=0, and the next step occurs 4 cycles later.
- Parameter variant LED_NUM=8, ACTIVE_LOW=0, mode=00 → led sequence 0x80, 0x40, …, 0x01, 0x80.
- Reset mid-run: assert sys_rst_n asynchronously between clock edges → led=0x80 immediately.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaled step strobe advances one of four
// run-time selectable patterns (rotate right/left, bounce, fill bar).
// Everything runs on sys_clk; the prescaler only produces a clock enable.
module led_pattern_gen #(
    parameter int LED_NUM    = 4,
    parameter int CNT_MAX    = 24_999_999,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] led,
    output logic               step_pulse
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int LVL_W = $clog2(LED_NUM + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CNT_MAX);
    localparam logic [LVL_W-1:0]   LVL_FULL   = LVL_W'(LED_NUM);
    localparam logic [LED_NUM-1:0] ONEHOT_MSB = {1'b1, {(LED_NUM-1){1'b0}}};
    localparam logic [LED_NUM-1:0] LED_RST    = ACTIVE_LOW ? ~ONEHOT_MSB : ONEHOT_MSB;

    typedef enum logic [1:0] {
        MODE_ROR    = 2'b00,
        MODE_ROL    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    // Registered state
    logic [LED_NUM-1:0] pat;
    logic [CNT_W-1:0]   cnt;
    logic               dir;
    logic [LVL_W-1:0]   level;
    mode_e              mode_q;

    // Next-state values
    logic [LED_NUM-1:0] pat_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               dir_n;
    logic [LVL_W-1:0]   level_n;
    logic               tick;
    logic               mode_chg;

    // Lit map for the fill bar: the top lvl bits are on.
    function automatic logic [LED_NUM-1:0] fill_map(input logic [LVL_W-1:0] lvl);
        logic [LED_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            m[i] = (i >= LED_NUM - int'(lvl));
        end
        return m;
    endfunction

    assign tick     = en && (cnt == CNT_LAST);
    assign mode_chg = (mode != mode_q);

    // Next-state logic: a mode change reloads the start pattern and wins over a tick.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        pat_n   = pat;
        cnt_n   = cnt;
        dir_n   = dir;
        level_n = level;
        if (mode_chg) begin
            cnt_n   = '0;
            dir_n   = 1'b0;
            level_n = '0;
            pat_n   = (mode == MODE_FILL) ? '0 : ONEHOT_MSB;
        end else if (en) begin
            cnt_n = tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                case (mode_q)
                    MODE_ROR: pat_n = {pat[0], pat[LED_NUM-1:1]};
                    MODE_ROL: pat_n = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
                    MODE_BOUNCE: begin
                        if (!dir) begin
                            if (pat[0]) begin
                                dir_n = 1'b1;
                                pat_n = pat << 1;
                            end else begin
                                pat_n = pat >> 1;
                            end
                        end else begin
                            if (pat[LED_NUM-1]) begin
                                dir_n = 1'b0;
                                pat_n = pat >> 1;
                            end else begin
                                pat_n = pat << 1;
                            end
                        end
                    end
                    default: begin
                        level_n = (level == LVL_FULL) ? '0 : level + LVL_W'(1);
                        pat_n   = fill_map(level_n);
                    end
                endcase
            end
        end
    end

    // State, LED drive and step strobe registers; mode_q captures mode while in reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat        <= ONEHOT_MSB;
            cnt        <= '0;
            dir        <= 1'b0;
            level      <= '0;
            mode_q     <= mode_e'(mode);
            led        <= LED_RST;
            step_pulse <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            pat        <= pat_n;
            cnt        <= cnt_n;
            dir        <= dir_n;
            level      <= level_n;
            mode_q     <= mode_e'(mode);
            led        <= ACTIVE_LOW ? ~pat_n : pat_n;
            step_pulse <= tick && !mode_chg;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus pushes (led, cycle) pairs,
// monitors pop and compare whenever step_pulse is high.
module tb_led_pattern_gen;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rst_v_n   = 1'b0;
    logic       en        = 1'b1;
    logic [1:0] mode      = 2'b00;
    logic [3:0] led;
    logic       step_pulse;
    logic [7:0] led_v;
    logic       step_v;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int r        = 0;
    int c        = 0;

    typedef struct {
        logic [7:0] led;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t qv[$];

    led_pattern_gen #(.LED_NUM(4), .CNT_MAX(3), .ACTIVE_LOW(1'b1)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .en         (en),
        .mode       (mode),
        .led        (led),
        .step_pulse (step_pulse)
    );

    led_pattern_gen #(.LED_NUM(8), .CNT_MAX(3), .ACTIVE_LOW(1'b0)) dut_v (
        .sys_clk    (sys_clk),
        .sys_rst_n  (rst_v_n),
        .en         (1'b1),
        .mode       (2'b00),
        .led        (led_v),
        .step_pulse (step_v)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] l, input int at);
        q.push_back('{led: l, cyc: at});
    endtask

    task automatic push_v(input logic [7:0] l, input int at);
        qv.push_back('{led: l, cyc: at});
    endtask

    // Main monitor: every strobe must match the next expected step in value and cycle.
    logic prev_p = 1'b0;
    always @(posedge sys_clk) begin
        #2;
        if (step_pulse === 1'b1) begin
            exp_t e;
            check(!prev_p, "pulse_width", prev_p, 0);
            check(q.size() > 0, "step_expected", q.size(), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(led === e.led[3:0], "step_led", led, e.led[3:0]);
                check(cyc == e.cyc, "step_cycle", cyc, e.cyc);
            end
        end
        prev_p = (step_pulse === 1'b1);
    end

    // Variant monitor for the 8-LED active-high instance.
    logic prev_v = 1'b0;
    always @(posedge sys_clk) begin
        #2;
        if (step_v === 1'b1) begin
            exp_t e;
            check(!prev_v, "v_pulse_width", prev_v, 0);
            check(qv.size() > 0, "v_step_expected", qv.size(), 1);
            if (qv.size() > 0) begin
                e = qv.pop_front();
                check(led_v === e.led, "v_step_led", led_v, e.led);
                check(cyc == e.cyc, "v_step_cycle", cyc, e.cyc);
            end
        end
        prev_v = (step_v === 1'b1);
    end

    task automatic wait_drain(input bit use_v, input int max_cyc);
        int n = 0;
        while (((use_v ? qv.size() : q.size()) != 0) && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        if (use_v) begin
            check(qv.size() == 0, "v_drain", qv.size(), 0);
            qv.delete();
        end else begin
            check(q.size() == 0, "drain", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        mode      = m;
        en        = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        r         = cyc;
        check(led === 4'b0111, "rst_led", led, 4'b0111);
        check(step_pulse === 1'b0, "rst_pulse", step_pulse, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (checks=%0d)", checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge sys_clk);

        // Rotate right from reset
        do_reset(2'b00);
        push(8'h0B, r + 4);
        push(8'h0D, r + 8);
        push(8'h0E, r + 12);
        push(8'h07, r + 16);
        wait_drain(1'b0, 24);

        // Rotate left, mode held through reset
        do_reset(2'b01);
        push(8'h0E, r + 4);
        push(8'h0D, r + 8);
        push(8'h0B, r + 12);
        push(8'h07, r + 16);
        wait_drain(1'b0, 24);

        // Bounce: lit bit 3,2,1,0,1,2,3,2
        do_reset(2'b10);
        push(8'h0B, r + 4);
        push(8'h0D, r + 8);
        push(8'h0E, r + 12);
        push(8'h0D, r + 16);
        push(8'h0B, r + 20);
        push(8'h07, r + 24);
        push(8'h0B, r + 28);
        wait_drain(1'b0, 36);

        // Fill bar entered through a mode change
        do_reset(2'b00);
        @(negedge sys_clk);
        mode = 2'b11;
        c    = cyc;
        push(8'h07, c + 5);
        push(8'h03, c + 9);
        push(8'h01, c + 13);
        push(8'h00, c + 17);
        push(8'h0F, c + 21);
        @(negedge sys_clk);
        check(led === 4'b1111, "fill_reload_led", led, 4'b1111);
        check(step_pulse === 1'b0, "fill_reload_pulse", step_pulse, 0);
        wait_drain(1'b0, 30);

        // Pause for 10 cycles with cnt=2
        do_reset(2'b00);
        push(8'h0B, r + 14);
        push(8'h0D, r + 18);
        repeat (2) @(negedge sys_clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (i % 3 == 0) check(led === 4'b0111, "pause_led", led, 4'b0111);
        end
        en = 1'b1;
        wait_drain(1'b0, 16);

        // Mode change coincident with a tick
        do_reset(2'b00);
        push(8'h0B, r + 4);
        repeat (7) @(negedge sys_clk);
        mode = 2'b11;
        push(8'h07, r + 12);
        push(8'h03, r + 16);
        @(negedge sys_clk);
        check(led === 4'b1111, "coinc_led", led, 4'b1111);
        check(step_pulse === 1'b0, "coinc_pulse", step_pulse, 0);
        wait_drain(1'b0, 16);

        // 8-LED active-high variant, then asynchronous reset mid-run
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        rst_v_n   = 1'b1;
        r         = cyc;
        check(led_v === 8'h80, "v_rst_led", led_v, 8'h80);
        check(step_v === 1'b0, "v_rst_pulse", step_v, 0);
        push_v(8'h40, r + 4);
        push_v(8'h20, r + 8);
        push_v(8'h10, r + 12);
        push_v(8'h08, r + 16);
        push_v(8'h04, r + 20);
        push_v(8'h02, r + 24);
        push_v(8'h01, r + 28);
        push_v(8'h80, r + 32);
        push_v(8'h40, r + 36);
        wait_drain(1'b1, 44);
        #2;
        rst_v_n = 1'b0;
        #1;
        check(led_v === 8'h80, "v_async_rst_led", led_v, 8'h80);
        check(step_v === 1'b0, "v_async_rst_pulse", step_v, 0);

        // Asynchronous reset of the main instance mid-run
        do_reset(2'b00);
        push(8'h0B, r + 4);
        wait_drain(1'b0, 8);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check(led === 4'b0111, "async_rst_led", led, 4'b0111);
        check(step_pulse === 1'b0, "async_rst_pulse", step_pulse, 0);

        repeat (6) @(negedge sys_clk);
        check(q.size() == 0 && qv.size() == 0, "final_queues", q.size() + qv.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
